// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned MaxWidth = 32;

    // Magnitude of a w-bit operand held in the low bits of v; raw value when sgn is 0.
    function automatic logic [MaxWidth-1:0] abs_w(input logic [MaxWidth-1:0] v,
                                                  input int unsigned          w,
                                                  input logic                 sgn);
        logic [MaxWidth:0] mask;
        logic [MaxWidth:0] neg;
        mask = (33'd1 << w) - 33'd1;
        neg  = ({1'b0, ~v} + 33'd1) & mask;
        if (sgn && v[5'(w - 1)]) begin
            return neg[MaxWidth-1:0];
        end
        return v;
    endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: operand capture, one multiplier bit per step, final sign fix-up.
module mul_seq_dp
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 finish_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 signed_i,
    output logic [CNT_W-1:0]     cnt_o,
    output logic [2*WIDTH-1:0]   product_o
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   pre;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Multiplier sits in the low half and is consumed LSB-first as the sum shifts in.
    always_comb begin
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        pre       = acc_q[0] ? {sum, acc_q[WIDTH-1:0]} : acc_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (load_i) begin
            mcand_d = WIDTH'(abs_w(MaxWidth'(a_i), WIDTH, signed_i));
            acc_d   = {{(WIDTH + 1){1'b0}}, WIDTH'(abs_w(MaxWidth'(b_i), WIDTH, signed_i))};
            neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            cnt_d   = '0;
        end else if (step_i) begin
            acc_d = {1'b0, pre[2*WIDTH:1]};
            cnt_d = cnt_q + 1'b1;
        end else if (finish_i) begin
            // A zero magnitude never picks up the sign, so -0 cannot appear.
            product_d = (neg_q && (acc_q[2*WIDTH-1:0] != '0)) ? -acc_q[2*WIDTH-1:0]
                                                               : acc_q[2*WIDTH-1:0];
        end
    end

    assign cnt_o     = cnt_q;
    assign product_o = product_q;

endmodule

// File: rtl/mul_seq_hs.sv
// Iterative signed/unsigned multiplier with valid/ready handshakes on both sides.
module mul_seq_hs
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    state_e           state_q, state_d;
    logic             load, step, finish;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // CALC spends WIDTH cycles stepping plus one cycle loading the result.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (cnt == CNT_W'(WIDTH)) begin
                    finish  = 1'b1;
                    state_d = StDone;
                end else begin
                    step = 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    mul_seq_dp #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (load),
        .step_i    (step),
        .finish_i  (finish),
        .a_i       (a),
        .b_i       (b),
        .signed_i  (signed_mode),
        .cnt_o     (cnt),
        .product_o (product)
    );

endmodule
